// File: rtl/julia_io_pkg.sv
// Shared types and ASCII helpers for the Julia-set front-panel I/O.
// State encoding, LCD geometry and the nibble-to-hex-character mapping live here.
package julia_io_pkg;

  typedef enum logic [1:0] {
    S_ENTER   = 2'd0,
    S_CONFIRM = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam int unsigned LCD_CHARS  = 32;
  localparam int unsigned LINE_CHARS = LCD_CHARS / 2;

  localparam logic [7:0]  ASCII_SPACE      = 8'h20;
  localparam logic [15:0] ASCII_HEX_PREFIX = 16'h3078;  // "0x"

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/hex_ascii_fmt.sv
// Formats a WIDTH-bit value as a space-padded 16-char LCD line "0x" + uppercase hex.
// Digits are MSB first; the value is zero-extended to a whole number of nibbles.
module hex_ascii_fmt
  import julia_io_pkg::*;
#(
  parameter int unsigned WIDTH = 18
) (
  input  logic [WIDTH-1:0]        value,
  output logic [LINE_CHARS*8-1:0] line
);

  localparam int unsigned NDIG  = (WIDTH + 3) / 4;
  localparam int unsigned TOP   = LINE_CHARS * 8 - 1;

  logic [NDIG*4-1:0] ext;

  always_comb begin
    ext              = '0;
    ext[WIDTH-1:0]   = value;
    line             = {LINE_CHARS{ASCII_SPACE}};
    line[TOP -: 16]  = ASCII_HEX_PREFIX;
    for (int unsigned i = 0; i < NDIG; i++) begin
      line[TOP - 16 - 8*i -: 8] = nibble_to_ascii(ext[(NDIG-1-i)*4 +: 4]);
    end
  end

endmodule

// File: rtl/param_entry_seq.sv
// Front-panel parameter-entry sequencer: steps through NUM_PARAMS values with
// enter/confirm/back, commits them to a packed bus and renders a 32-char LCD image.
module param_entry_seq
  import julia_io_pkg::*;
#(
  parameter int unsigned                   WIDTH      = 18,
  parameter int unsigned                   NUM_PARAMS = 5,
  parameter int unsigned                   IDX_W      = 4,
  parameter logic [NUM_PARAMS*WIDTH-1:0]   DEFAULTS   = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [WIDTH-1:0]            sw,
  input  logic                        enter,
  input  logic                        confirm,
  input  logic                        back,
  output logic [NUM_PARAMS*WIDTH-1:0] params_out,
  output logic [IDX_W-1:0]            cur_idx,
  output logic                        params_valid,
  output logic                        update_pulse,
  output logic [LCD_CHARS*8-1:0]      lcd_text
);

  localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(NUM_PARAMS - 1);
  localparam logic [LCD_CHARS*8-1:0] LCD_RESET = {"ENTER P0", {(LCD_CHARS-8){ASCII_SPACE}}};

  state_t                      state, state_next;
  logic [IDX_W-1:0]            idx_q, idx_next;
  logic [WIDTH-1:0]            staging, staging_next;
  logic [NUM_PARAMS*WIDTH-1:0] params_q;
  logic                        commit;
  logic                        pulse_q, pulse_next;

  logic enter_prev, confirm_prev, back_prev;
  logic ev_enter, ev_confirm, ev_back;

  logic [WIDTH-1:0]            fmt_value;
  logic [LINE_CHARS*8-1:0]     fmt_line;
  logic [LINE_CHARS*8-1:0]     line1, line2;
  logic [LCD_CHARS*8-1:0]      lcd_q;
  logic [IDX_W+3:0]            idx_ext;

  assign ev_enter   = enter   & ~enter_prev;
  assign ev_confirm = confirm & ~confirm_prev;
  assign ev_back    = back    & ~back_prev;

  // Edge priority back > confirm > enter: each state tests back first, and an
  // enter edge is acted on only when no confirm edge coincides with it.
  always_comb begin
    state_next   = state;
    idx_next     = idx_q;
    staging_next = staging;
    commit       = 1'b0;
    pulse_next   = 1'b0;
    unique case (state)
      S_ENTER: begin
        if (ev_back) begin
          if (idx_q != '0) idx_next = idx_q - 1'b1;
        end else if (ev_enter && !ev_confirm) begin
          staging_next = sw;
          state_next   = S_CONFIRM;
        end
      end
      S_CONFIRM: begin
        if (ev_back) begin
          staging_next = '0;
          state_next   = S_ENTER;
        end else if (ev_confirm) begin
          commit = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_next = S_DONE;
            pulse_next = 1'b1;
          end else begin
            idx_next   = idx_q + 1'b1;
            state_next = S_ENTER;
          end
        end
      end
      S_DONE: begin
        if (ev_back) begin
          idx_next   = LAST_IDX;
          state_next = S_ENTER;
        end else if (ev_enter && !ev_confirm) begin
          idx_next   = '0;
          state_next = S_ENTER;
        end
      end
      default: state_next = S_ENTER;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_ENTER;
      idx_q        <= '0;
      staging      <= '0;
      pulse_q      <= 1'b0;
      enter_prev   <= 1'b1;
      confirm_prev <= 1'b1;
      back_prev    <= 1'b1;
    end else begin
      state        <= state_next;
      idx_q        <= idx_next;
      staging      <= staging_next;
      pulse_q      <= pulse_next;
      enter_prev   <= enter;
      confirm_prev <= confirm;
      back_prev    <= back;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      params_q <= DEFAULTS;
    end else begin
      for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
        if (commit && idx_q == IDX_W'(i)) params_q[i*WIDTH +: WIDTH] <= staging;
      end
    end
  end

  // One formatter serves both editing states.
  assign fmt_value = (state == S_CONFIRM) ? staging : sw;

  hex_ascii_fmt #(
    .WIDTH (WIDTH)
  ) u_fmt (
    .value (fmt_value),
    .line  (fmt_line)
  );

  assign idx_ext = {4'h0, idx_q};

  always_comb begin
    line1 = {LINE_CHARS{ASCII_SPACE}};
    line2 = {LINE_CHARS{ASCII_SPACE}};
    unique case (state)
      S_ENTER: begin
        line1[LINE_CHARS*8-1 -: 56]  = "ENTER P";
        line1[LINE_CHARS*8-57 -: 8]  = nibble_to_ascii(idx_ext[3:0]);
        line2                        = fmt_line;
      end
      S_CONFIRM: begin
        line1[LINE_CHARS*8-1 -: 72]  = "CONFIRM P";
        line1[LINE_CHARS*8-73 -: 8]  = nibble_to_ascii(idx_ext[3:0]);
        line2                        = fmt_line;
      end
      S_DONE: begin
        line1[LINE_CHARS*8-1 -: 32]  = "DONE";
        line2[LINE_CHARS*8-1 -: 40]  = "READY";
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) lcd_q <= LCD_RESET;
    else        lcd_q <= {line1, line2};
  end

  assign params_out   = params_q;
  assign cur_idx      = idx_q;
  assign params_valid = (state == S_DONE);
  assign update_pulse = pulse_q;
  assign lcd_text     = lcd_q;

endmodule

// File: doc/param_entry_seq.md
Name: param_entry_seq

Overview:
- Parametrised front-panel parameter-entry sequencer for the Julia-set renderer.
- Walks the operator through NUM_PARAMS fixed-point parameters (c_real, c_comp, z_real, z_comp, z_scale, ...) with enter/confirm/back buttons.
- Holds committed values on a packed bus for the fractal engine and drives a 32-char LCD image showing prompt, index and hex value.
- Adds over the previous generation: button edge detection, back/undo, reset defaults, a done/valid handshake, and hex readout.

Parameters:
WIDTH, 18, bits per parameter; legal 4..48
NUM_PARAMS, 5, number of parameters; legal 1..16
IDX_W, 4, index width; must satisfy 2**IDX_W >= NUM_PARAMS
DEFAULTS, {NUM_PARAMS*WIDTH{1'b0}}, packed reset values; param i at bits [i*WIDTH +: WIDTH]

Ports:
clock  in  1  system clock, all logic posedge
reset  in  1  asynchronous, active-low reset
sw  in  WIDTH  switch value, already synchronised upstream
enter  in  1  level, active-high, debounced
confirm  in  1  level, active-high, debounced
back  in  1  level, active-high, debounced
params_out  out  NUM_PARAMS*WIDTH  committed parameters, packed as DEFAULTS
cur_idx  out  IDX_W  index being edited
params_valid  out  1  high while in S_DONE
update_pulse  out  1  one-cycle strobe on entry to S_DONE
lcd_text  out  256  LCD image, char 0 at [255:248]; line 1 = chars 0-15, line 2 = chars 16-31

Behaviour:
- Reset (reset==0, async) values:
  - state=S_ENTER, cur_idx=0, params_out=DEFAULTS, staging=0.
  - params_valid=0, update_pulse=0.
  - lcd_text = "ENTER P0" padded with spaces to 32 chars.
  - Edge-history regs = 1, so a button held through reset produces no edge.
- Edge detect: ev_x = x & ~x_prev, registered each cycle. Action occurs in the cycle the edge is seen. Level-held buttons fire once.
- Priority when edges coincide: back > confirm > enter. Lower-priority edges in the same cycle are dropped.
- S_ENTER:
  - ev_enter: staging<=sw, go S_CONFIRM.
  - ev_back and cur_idx>0: cur_idx-1, stay. ev_back at idx 0: no-op.
  - ev_confirm: ignored.
- S_CONFIRM:
  - ev_confirm: params_out[cur_idx]<=staging.
    - If cur_idx==NUM_PARAMS-1: go S_DONE, update_pulse=1 next cycle only.
    - Else: cur_idx+1, go S_ENTER.
  - ev_back: discard staging, go S_ENTER, same idx.
  - ev_enter: ignored; no recapture.
- S_DONE:
  - params_valid=1.
  - ev_enter: cur_idx<=0, go S_ENTER, params_valid<=0. params_out holds until individually overwritten.
  - ev_back: cur_idx<=NUM_PARAMS-1, go S_ENTER, params_valid<=0.
- params_out changes only on a commit or reset. Never partially written.
- NUM_PARAMS==1: confirm in S_CONFIRM goes straight to S_DONE.
- lcd_text is registered, 1 cycle after state/sw.
  - Line 1: "ENTER P" / "CONFIRM P" + hex digit of cur_idx, or "DONE". Space padded.
  - Line 2 in S_ENTER: "0x" + ceil(WIDTH/4) uppercase hex digits of live sw, MSB first, zero-extended.
  - Line 2 in S_CONFIRM: same format from staging.
  - Line 2 in S_DONE: "READY". Space padded.

Decomposition:
- Package julia_io_pkg:
  - state encoding S_ENTER=2'd0, S_CONFIRM=2'd1, S_DONE=2'd2.
  - ASCII constants (space, "0x").
  - LCD_CHARS=32.
  - Function nibble_to_ascii.
- Sub-module hex_ascii_fmt #(WIDTH):
  - combinational.
  - value -> space-padded 16-char line "0x"+hex.
  - Instantiated once; input muxed between sw and staging.

Test Plan:
1. Reset with DEFAULTS={5{18'h00100}}, enter held high through reset release -> no transition; cur_idx=0; params_out=DEFAULTS; lcd line1 "ENTER P0".
2. Five iterations of sw=18'h2ABCD, pulse enter, pulse confirm -> each slot = 18'h2ABCD. update_pulse high exactly one cycle after 5th confirm. params_valid=1. line1 "DONE", line2 "READY".
3. idx 2, sw=18'h00FFF, enter; then back -> staging discarded, S_ENTER idx 2, params_out[2] unchanged. back again -> idx 1. back at idx 0 -> stays 0.
4. In S_CONFIRM, back+confirm+enter rising same cycle -> back wins: S_ENTER, no commit.
5. S_CONFIRM with confirm held 10 cycles -> single commit, idx +1 only. Then sw=18'h3FFFF with no enter edge -> lcd line2 "0x3FFFF" one cycle later, no commit.
6. Reset asserted mid-S_CONFIRM at idx 3 -> same cycle: idx 0, params_out=DEFAULTS, params_valid=0, update_pulse=0.
